// File: rtl/mul256_arbiter.sv
// mul256_arbiter: shares one 256x256 multiplier between NUM_REQ requesters.
// It grants requests round-robin, captures the winner's operands, runs the
// multiplier start/done handshake and returns the 512-bit product (or a
// timeout abort) to the originating requester together with its index.
// Jobs are not pipelined: one job is in flight from grant to response.
// TIMEOUT must be at least 2 and larger than the multiplier latency.

module mul256_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*256-1:0] req_in1,
    input  logic [NUM_REQ*256-1:0] req_in2,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [511:0]           rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [255:0]           mul_in1,
    output logic [255:0]           mul_in2,
    input  logic [511:0]           mul_out,
    input  logic                   mul_done
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [511:0]       rsp_data_q;
    logic               rsp_err_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [255:0]       mul_in1_q;
    logic [255:0]       mul_in2_q;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    int unsigned        scan_idx;
    logic               timeout_hit;

    // Round-robin pick: first valid requester scanning upward from ptr_q with wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_valid && req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
        ptr_next = (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    // Next-state logic; a done outside StWait has no effect on the sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mul_done || timeout_hit) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, operand capture, arbitration pointer and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_in1_q   <= '0;
            mul_in2_q   <= '0;
        end else begin
            // Pulsed outputs default low; busy mirrors the upcoming state.
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            busy_q      <= (state_d != StIdle);
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        req_ready_q[grant_idx] <= 1'b1;
                        mul_in1_q <= req_in1[int'(grant_idx)*256 +: 256];
                        mul_in2_q <= req_in2[int'(grant_idx)*256 +: 256];
                        owner_q   <= grant_idx;
                        ptr_q     <= ptr_next;
                    end
                end
                StIssue: begin
                    mul_start_q <= 1'b1;
                    cnt_q       <= '0;
                end
                StWait: begin
                    if (mul_done) begin
                        rsp_data_q           <= mul_out;
                        rsp_id_q             <= owner_q;
                        rsp_err_q            <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_data_q           <= '0;
                        rsp_id_q             <= owner_q;
                        rsp_err_q            <= 1'b1;
                        rsp_valid_q[owner_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_in1   = mul_in1_q;
    assign mul_in2   = mul_in2_q;

endmodule

// File: tb/tb_mul256_arbiter.sv
// Directed bench for mul256_arbiter with a behavioural multiplier of latency L.
// Cycle k is the value visible just after the k-th rising edge.

module tb_mul256_arbiter;

    localparam int NR = 4;
    localparam int TO = 64;
    localparam int L  = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*256-1:0] req_in1;
    logic [NR*256-1:0] req_in2;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [1:0]        rsp_id;
    logic [511:0]      rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [255:0]      mul_in1;
    logic [255:0]      mul_in2;
    logic [511:0]      mul_out;
    logic              mul_done;

    logic              done_en;
    logic              inj_done;
    logic [511:0]      inj_out;
    logic              mdl_done;
    logic              mdl_active;
    int                mdl_cnt;
    logic [255:0]      mdl_a;
    logic [255:0]      mdl_b;
    logic [511:0]      mdl_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul256_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_in1(req_in1),
        .req_in2(req_in2),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy),
        .mul_start(mul_start),
        .mul_in1(mul_in1),
        .mul_in2(mul_in2),
        .mul_out(mul_out),
        .mul_done(mul_done)
    );

    // Behavioural multiplier: done is high L cycles after the start cycle.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (reset) begin
            mdl_active <= 1'b0;
            mdl_cnt    <= 0;
        end else if (mul_start) begin
            mdl_a      <= mul_in1;
            mdl_b      <= mul_in2;
            mdl_cnt    <= 1;
            mdl_active <= 1'b1;
        end else if (mdl_active) begin
            if (mdl_cnt == L - 1) begin
                mdl_done   <= done_en;
                mdl_out    <= 512'(mdl_a) * 512'(mdl_b);
                mdl_active <= 1'b0;
            end
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    assign mul_done = mdl_done | inj_done;
    assign mul_out  = inj_done ? inj_out : mdl_out;

    // Product of operands (i+1) and 2^256-1: (i+1)*2^256 - (i+1).
    function automatic logic [511:0] ones_prod(input int i);
        logic [511:0] m;
        m = 512'(i + 1);
        return (m << 256) - m;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits for a grant, drops that requester's valid; idx = -1 if none.
    task automatic wait_ready(input int limit, output int idx, output int lat);
        int c;
        idx = -1;
        lat = 0;
        c = 0;
        while (idx < 0 && c < limit) begin
            @(posedge clk);
            #1;
            c++;
            if (req_ready != '0) begin
                lat = c;
                for (int k = 0; k < NR; k++) if (req_ready[k]) idx = k;
                req_valid[idx] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(input int limit, output int idx, output int lat);
        int c;
        idx = -1;
        lat = 0;
        c = 0;
        while (idx < 0 && c < limit) begin
            @(posedge clk);
            #1;
            c++;
            if (rsp_valid != '0) begin
                lat = c;
                for (int k = 0; k < NR; k++) if (rsp_valid[k]) idx = k;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, busy, mul_start} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b valid=%b id=%0d err=%b busy=%b start=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_err, busy, mul_start);
        end
        checks++;
        if ({rsp_data, mul_in1, mul_in2} !== '0) begin
            failures++;
            $display("FAIL reset_data: rsp_data=%h mul_in1=%h mul_in2=%h, want 0",
                     rsp_data, mul_in1, mul_in2);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int g, r, lat;
        logic [511:0] exp;
        exp = 512'd3 << 255;
        req_in1[255:0] = {1'b1, 255'b0};
        req_in2[255:0] = 256'd3;
        req_valid = 4'b0001;
        wait_ready(10, g, lat);
        checks++;
        if (g !== 0 || lat !== 1) begin
            failures++;
            $display("FAIL single_grant: idx=%0d cycle=%0d, want idx=0 cycle=1", g, lat);
        end
        checks++;
        if (mul_in1 !== {1'b1, 255'b0} || mul_in2 !== 256'd3) begin
            failures++;
            $display("FAIL single_capture: in1=%h in2=%h", mul_in1, mul_in2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mul_start !== 1'b1 || req_ready !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start: start=%b ready=%b busy=%b, want 1 0000 1",
                     mul_start, req_ready, busy);
        end
        wait_rsp(100, r, lat);
        checks++;
        if (r !== 0 || lat !== 24) begin
            failures++;
            $display("FAIL single_rsp_time: idx=%0d cycle=%0d, want idx=0 cycle=26", r, lat + 2);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== exp || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp_data: id=%0d err=%b data=%h, want 0 0 %h",
                     rsp_id, rsp_err, rsp_data, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_data !== exp) begin
            failures++;
            $display("FAIL single_hold: valid=%b busy=%b data=%h", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        int g, r, lat;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_in1[256*i +: 256] = 256'(i + 1);
            req_in2[256*i +: 256] = '1;
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ready(40, g, lat);
            checks++;
            if (g !== order[n] || $countones(req_ready) != 1 || (n > 0 && lat !== 2)) begin
                failures++;
                $display("FAIL rr_grant%0d: idx=%0d ready=%b wait=%0d, want idx=%0d",
                         n, g, req_ready, lat, order[n]);
            end
            wait_rsp(40, r, lat);
            checks++;
            if (r !== order[n] || rsp_id !== 2'(order[n]) || rsp_err !== 1'b0
                || rsp_data !== ones_prod(order[n])) begin
                failures++;
                $display("FAIL rr_rsp%0d: idx=%0d id=%0d err=%b data=%h, want %0d",
                         n, r, rsp_id, rsp_err, rsp_data, order[n]);
            end
            if (n < 4 && g >= 0) req_valid[g] = 1'b1;
            else req_valid = '0;
        end
    endtask

    // Starts with ptr=1; each step raises new requests at the previous response.
    task automatic test_ptr_wrap();
        int g, r, lat;
        logic [NR-1:0] raise[5] = '{4'b0010, 4'b1001, 4'b1000, 4'b0010, 4'b0000};
        int exp_g[5] = '{1, 3, 0, 1, 3};
        for (int n = 0; n < 5; n++) begin
            req_valid = req_valid | raise[n];
            wait_ready(40, g, lat);
            checks++;
            if (g !== exp_g[n]) begin
                failures++;
                $display("FAIL ptr_grant%0d: idx=%0d, want %0d", n, g, exp_g[n]);
            end
            wait_rsp(40, r, lat);
            checks++;
            if (r !== exp_g[n] || rsp_data !== ones_prod(exp_g[n])) begin
                failures++;
                $display("FAIL ptr_rsp%0d: idx=%0d data=%h, want %0d", n, r, rsp_data, exp_g[n]);
            end
        end
    endtask

    // ptr=0 on entry; the stalled job aborts after TIMEOUT cycles in WAIT.
    task automatic test_timeout();
        int g, r, lat;
        done_en = 1'b0;
        req_valid = 4'b0100;
        wait_ready(10, g, lat);
        @(posedge clk);
        #1;
        checks++;
        if (g !== 2 || mul_start !== 1'b1) begin
            failures++;
            $display("FAIL to_issue: idx=%0d start=%b, want 2 1", g, mul_start);
        end
        wait_rsp(100, r, lat);
        checks++;
        if (r !== 2 || lat !== TO || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL to_abort: idx=%0d after=%0d err=%b id=%0d data=%h, want 2 %0d 1 2 0",
                     r, lat, rsp_err, rsp_id, rsp_data, TO);
        end
        @(posedge clk);
        #1 inj_out = {16{32'hdeadbeef}};
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        wait_rsp(30, r, lat);
        checks++;
        if (r !== -1 || busy !== 1'b0 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            failures++;
            $display("FAIL to_late_done: rsp idx=%0d busy=%b err=%b data=%h, want none",
                     r, busy, rsp_err, rsp_data);
        end
        done_en = 1'b1;
        req_valid = 4'b1000;
        wait_ready(10, g, lat);
        wait_rsp(40, r, lat);
        checks++;
        if (g !== 3 || r !== 3 || rsp_err !== 1'b0 || rsp_data !== ones_prod(3)) begin
            failures++;
            $display("FAIL to_recover: grant=%0d rsp=%0d err=%b data=%h", g, r, rsp_err, rsp_data);
        end
    endtask

    // ptr=0 on entry; granting 2 moves ptr to 3, which reset must clear.
    task automatic test_reset_wait();
        int g, r, lat;
        req_valid = 4'b0100;
        wait_ready(10, g, lat);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, busy, mul_start} !== '0
            || {rsp_data, mul_in1, mul_in2} !== '0) begin
            failures++;
            $display("FAIL rstw_outputs: valid=%b busy=%b start=%b data=%h, want all 0",
                     rsp_valid, busy, mul_start, rsp_data);
        end
        reset = 1'b0;
        wait_rsp(40, r, lat);
        checks++;
        if (r !== -1) begin
            failures++;
            $display("FAIL rstw_silent: rsp idx=%0d, want none", r);
        end
        req_valid = 4'b1100;
        wait_ready(10, g, lat);
        checks++;
        if (g !== 2) begin
            failures++;
            $display("FAIL rstw_ptr: idx=%0d, want 2", g);
        end
        wait_rsp(40, r, lat);
        wait_ready(10, g, lat);
        wait_rsp(40, r, lat);
        checks++;
        if (g !== 3 || r !== 3 || rsp_data !== ones_prod(3)) begin
            failures++;
            $display("FAIL rstw_next: grant=%0d rsp=%0d data=%h, want 3", g, r, rsp_data);
        end
    endtask

    // ptr=0 on entry; stray done pulses in IDLE and ISSUE are ignored.
    task automatic test_spurious_done();
        int g, r, lat;
        inj_out = {16{32'h5a5a5a5a}};
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        wait_rsp(5, r, lat);
        checks++;
        if (r !== -1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle: rsp idx=%0d busy=%b, want none 0", r, busy);
        end
        req_valid = 4'b0010;
        wait_ready(10, g, lat);
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        checks++;
        if (g !== 1 || mul_start !== 1'b1 || rsp_valid !== '0) begin
            failures++;
            $display("FAIL spur_issue: grant=%0d start=%b valid=%b", g, mul_start, rsp_valid);
        end
        wait_rsp(40, r, lat);
        checks++;
        if (r !== 1 || lat !== 24 || rsp_err !== 1'b0 || rsp_data !== ones_prod(1)) begin
            failures++;
            $display("FAIL spur_rsp: idx=%0d after=%0d err=%b data=%h, want 1 24 0",
                     r, lat, rsp_err, rsp_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_in1 = '0;
        req_in2 = '0;
        done_en = 1'b1;
        inj_done = 1'b0;
        inj_out = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_timeout();
        test_reset_wait();
        test_spurious_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
